// File: rtl/bp_gshare.sv
// gshare branch predictor: 2-bit counter PHT indexed by PC ^ committed history,
// tagged direct-mapped BTB, and an optional return address stack built when BP_RAS_EN is defined.
module bp_gshare #(
  parameter int GHR_WIDTH       = 5,
  parameter int BTB_INDEX_WIDTH = 6,
  parameter int RAS_DEPTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_in,
  input  logic                 upd_valid,
  input  logic                 upd_is_branch,
  input  logic                 upd_is_jump,
  input  logic                 upd_is_call,
  input  logic                 upd_is_return,
  input  logic                 upd_taken,
  input  logic [GHR_WIDTH-1:0] upd_pht_index,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_pht_index,
  output logic [31:0]          next_pc_out
);
  // Update port is a valid-only strobe: the upd_* bundle is consumed on every
  // rising edge where upd_valid is high; there is no ready, it is always accepted.

  localparam int PHT_SIZE = 1 << GHR_WIDTH;
  localparam int BTB_SIZE = 1 << BTB_INDEX_WIDTH;
  localparam int TAG_W    = 30 - BTB_INDEX_WIDTH;

  typedef enum logic [1:0] {
    BT_BRANCH = 2'd0,
    BT_JUMP   = 2'd1,
    BT_CALL   = 2'd2,
    BT_RETURN = 2'd3
  } btb_type_e;

  logic [GHR_WIDTH-1:0] ghr;
  logic [1:0]           pht        [PHT_SIZE];
  logic [BTB_SIZE-1:0]  btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_SIZE];
  logic [31:0]          btb_target [BTB_SIZE];
  btb_type_e            btb_type   [BTB_SIZE];

  logic [BTB_INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_W-1:0]           lk_tag;
  logic                       lk_hit;
  btb_type_e                  lk_type;
  logic [1:0]                 lk_ctr;
  logic [31:0]                lk_target;

  assign lk_idx         = pc_in[BTB_INDEX_WIDTH+1:2];
  assign lk_tag         = pc_in[31:BTB_INDEX_WIDTH+2];
  assign pred_pht_index = pc_in[GHR_WIDTH+1:2] ^ ghr;
  assign lk_ctr         = pht[pred_pht_index];
  assign lk_type        = btb_type[lk_idx];
  assign lk_hit         = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pred_taken     = lk_hit && ((lk_type == BT_BRANCH) ? lk_ctr[1] : 1'b1);
  assign next_pc_out    = pred_taken ? lk_target : pc_in + 32'd4;

  logic [BTB_INDEX_WIDTH-1:0] up_idx;
  logic                       btb_wr;
  btb_type_e                  up_type;
  logic [1:0]                 up_ctr_old;
  logic [1:0]                 up_ctr_new;

  assign up_idx = upd_pc[BTB_INDEX_WIDTH+1:2];
  assign btb_wr = upd_valid && (upd_is_branch || upd_is_jump) && upd_taken;

  always_comb begin
    up_type = BT_BRANCH;
    if (upd_is_return)    up_type = BT_RETURN;
    else if (upd_is_call) up_type = BT_CALL;
    else if (upd_is_jump) up_type = BT_JUMP;
  end

  always_comb begin
    up_ctr_old = pht[upd_pht_index];
    up_ctr_new = up_ctr_old;
    if (upd_taken && up_ctr_old != 2'b11)       up_ctr_new = up_ctr_old + 2'b01;
    else if (!upd_taken && up_ctr_old != 2'b00) up_ctr_new = up_ctr_old - 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr       <= '0;
      btb_valid <= '0;
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= 2'b01;
      for (int i = 0; i < BTB_SIZE; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_type[i]   <= BT_BRANCH;
      end
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        pht[upd_pht_index] <= up_ctr_new;
        ghr                <= {ghr[GHR_WIDTH-2:0], upd_taken};
      end
      // Aliasing entries are simply replaced; not-taken updates never touch the BTB.
      if (btb_wr) begin
        btb_valid[up_idx]  <= 1'b1;
        btb_tag[up_idx]    <= upd_pc[31:BTB_INDEX_WIDTH+2];
        btb_target[up_idx] <= upd_target;
        btb_type[up_idx]   <= up_type;
      end
    end
  end

`ifdef BP_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [31:0]      ras [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_top_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_nonempty;
  logic [31:0]      ras_push_val;
  logic             unused_bits;

  // ras_ptr is the next free slot; the top lives one below it, modulo depth.
  assign ras_top_ptr  = ras_ptr - PTR_W'(1);
  assign ras_nonempty = (ras_cnt != '0);
  assign ras_push_val = upd_pc + 32'd8;
  assign lk_target    = (lk_type == BT_RETURN && ras_nonempty) ? ras[ras_top_ptr]
                                                               : btb_target[lk_idx];
  assign unused_bits  = lk_ctr[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (upd_valid) begin
      if (upd_is_call && upd_is_return && ras_nonempty) begin
        ras[ras_top_ptr] <= ras_push_val;
      end else if (upd_is_call) begin
        // Full stack: the slot at ras_ptr holds the oldest entry, so it is overwritten.
        ras[ras_ptr] <= ras_push_val;
        ras_ptr      <= ras_ptr + PTR_W'(1);
        if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (upd_is_return && ras_nonempty) begin
        ras_ptr <= ras_top_ptr;
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end
`else
  logic unused_bits;

  assign lk_target   = btb_target[lk_idx];
  assign unused_bits = ^{lk_ctr[0], upd_pc[1:0], 32'(RAS_DEPTH)};
`endif

endmodule

// File: tb/tb_bp_gshare.sv
// Bench for bp_gshare: directed scenarios plus randomized updates/lookups against a
// table-level reference model of the predictor.
module tb_bp_gshare;
  localparam int G     = 5;
  localparam int BI    = 6;
  localparam int RD    = 8;
  localparam int PHT_N = 1 << G;
  localparam int BTB_N = 1 << BI;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_in;
  logic         upd_valid, upd_is_branch, upd_is_jump, upd_is_call, upd_is_return, upd_taken;
  logic [G-1:0] upd_pht_index;
  logic [31:0]  upd_pc, upd_target;
  logic         pred_taken;
  logic [G-1:0] pred_pht_index;
  logic [31:0]  next_pc_out;

  bp_gshare #(.GHR_WIDTH(G), .BTB_INDEX_WIDTH(BI), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_is_call(upd_is_call), .upd_is_return(upd_is_return), .upd_taken(upd_taken),
    .upd_pht_index(upd_pht_index), .upd_pc(upd_pc), .upd_target(upd_target),
    .pred_taken(pred_taken), .pred_pht_index(pred_pht_index), .next_pc_out(next_pc_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain arrays of counters and BTB records, history as an integer.
  int unsigned m_ghr;
  int unsigned m_pht    [PHT_N];
  bit          m_valid  [BTB_N];
  int unsigned m_tag    [BTB_N];
  logic [31:0] m_target [BTB_N];
  string       m_kind   [BTB_N];
`ifdef BP_RAS_EN
  logic [31:0] m_ras[$];
`endif

  function automatic void model_reset();
    m_ghr = 0;
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    for (int i = 0; i < BTB_N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_kind[i] = "branch";
    end
`ifdef BP_RAS_EN
    m_ras.delete();
`endif
  endfunction

  function automatic void model_update(input bit br, input bit jmp, input bit call, input bit ret,
                                       input bit taken, input int unsigned idx,
                                       input logic [31:0] pc, input logic [31:0] tgt);
    int unsigned b;
    if (br) begin
      if (taken) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
      else       m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
      m_ghr = ((m_ghr << 1) | int'(taken)) % PHT_N;
    end
    if ((br || jmp) && taken) begin
      b = (pc >> 2) % BTB_N;
      m_valid[b]  = 1;
      m_tag[b]    = pc >> (BI + 2);
      m_target[b] = tgt;
      m_kind[b]   = ret ? "return" : call ? "call" : jmp ? "jump" : "branch";
    end
`ifdef BP_RAS_EN
    if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
    if (call) begin
      m_ras.push_back(pc + 32'd8);
      if (m_ras.size() > RD) void'(m_ras.pop_front());
    end
`endif
  endfunction

  // Returns {pred_taken, pred_pht_index, next_pc_out}.
  function automatic logic [G+32:0] model_predict(input logic [31:0] pc);
    int unsigned idx, b;
    bit          hit, taken;
    logic [31:0] tgt, npc;
    logic [G-1:0] idx_v;
    idx = ((pc >> 2) ^ m_ghr) % PHT_N;
    b   = (pc >> 2) % BTB_N;
    hit = m_valid[b] && (m_tag[b] == (pc >> (BI + 2)));
    taken = hit && ((m_kind[b] == "branch") ? (m_pht[idx] >= 2) : 1'b1);
    tgt = m_target[b];
`ifdef BP_RAS_EN
    if (m_kind[b] == "return" && m_ras.size() > 0) tgt = m_ras[$];
`endif
    npc   = taken ? tgt : pc + 32'd4;
    idx_v = idx[G-1:0];
    return {taken, idx_v, npc};
  endfunction

  task automatic idle_inputs();
    upd_valid = 0; upd_is_branch = 0; upd_is_jump = 0; upd_is_call = 0; upd_is_return = 0;
    upd_taken = 0; upd_pht_index = '0; upd_pc = '0; upd_target = '0;
  endtask

  task automatic set_update(input bit br, input bit jmp, input bit call, input bit ret,
                            input bit taken, input int unsigned idx,
                            input logic [31:0] pc, input logic [31:0] tgt);
    upd_valid = 1; upd_is_branch = br; upd_is_jump = jmp; upd_is_call = call;
    upd_is_return = ret; upd_taken = taken; upd_pht_index = idx[G-1:0];
    upd_pc = pc; upd_target = tgt;
  endtask

  // One clock: the model absorbs whatever update the DUT samples at this edge.
  task automatic step();
    @(posedge clk);
    if (rst && upd_valid)
      model_update(upd_is_branch, upd_is_jump, upd_is_call, upd_is_return, upd_taken,
                   int'(upd_pht_index), upd_pc, upd_target);
    #1;
    idle_inputs();
  endtask

  task automatic do_update(input bit br, input bit jmp, input bit call, input bit ret,
                           input bit taken, input int unsigned idx,
                           input logic [31:0] pc, input logic [31:0] tgt);
    set_update(br, jmp, call, ret, taken, idx, pc, tgt);
    step();
  endtask

  task automatic test_reset();
    logic [G+32:0] exp_v;
    pc_in = 32'hbfc00010;
    #1;
    checks++;
    if ({pred_taken, pred_pht_index, next_pc_out} !== {1'b0, 5'h04, 32'hbfc00014}) begin
      failures++;
      $display("FAIL reset_lookup got %h want %h", {pred_taken, pred_pht_index, next_pc_out},
               {1'b0, 5'h04, 32'hbfc00014});
    end
    for (int i = 0; i < 4; i++) begin
      pc_in = $urandom() & 32'hffff_fffc;
      #1;
      exp_v = model_predict(pc_in);
      checks++;
      if ({pred_taken, pred_pht_index, next_pc_out} !== exp_v) begin
        failures++;
        $display("FAIL reset_random pc=%h got %h want %h", pc_in,
                 {pred_taken, pred_pht_index, next_pc_out}, exp_v);
      end
    end
  endtask

  task automatic test_first_branch();
    do_update(1, 0, 0, 0, 1, 4, 32'hbfc00010, 32'hbfc00124);
    pc_in = 32'hbfc00010;
    #1;
    checks++;
    if ({pred_taken, pred_pht_index, next_pc_out} !== {1'b0, 5'h05, 32'hbfc00014}) begin
      failures++;
      $display("FAIL first_branch got %h want %h", {pred_taken, pred_pht_index, next_pc_out},
               {1'b0, 5'h05, 32'hbfc00014});
    end
  endtask

  task automatic test_jump();
    logic [G+32:0] exp_v;
    do_update(0, 1, 0, 0, 1, $urandom_range(0, PHT_N - 1), 32'hbfc00020, 32'hbfc00400);
    pc_in = 32'hbfc00020;
    #1;
    exp_v = model_predict(pc_in);
    checks++;
    if ({pred_taken, next_pc_out} !== {1'b1, 32'hbfc00400}) begin
      failures++;
      $display("FAIL jump_hit got %h want %h", {pred_taken, next_pc_out}, {1'b1, 32'hbfc00400});
    end
    checks++;
    if (pred_pht_index !== exp_v[G+31:32]) begin
      failures++;
      $display("FAIL jump_pht_index got %h want %h", pred_pht_index, exp_v[G+31:32]);
    end
  endtask

  task automatic test_pht_saturation();
    for (int i = 0; i < 4; i++) do_update(1, 0, 0, 0, 1, 9, 32'hbfc0005c, 32'hbfc00900);
    do_update(1, 0, 0, 0, 0, 9, 32'hbfc0005c, 32'hbfc00900);
    // History is now 11110, so this PC indexes counter 9 (now 10).
    pc_in = 32'hbfc0005c;
    #1;
    checks++;
    if ({pred_taken, pred_pht_index, next_pc_out} !== {1'b1, 5'h09, 32'hbfc00900}) begin
      failures++;
      $display("FAIL pht_saturation got %h want %h", {pred_taken, pred_pht_index, next_pc_out},
               {1'b1, 5'h09, 32'hbfc00900});
    end
  endtask

  task automatic test_alias();
    logic [G+32:0] exp_v;
    do_update(1, 0, 0, 0, 1, $urandom_range(0, PHT_N - 1), 32'hbfc00010, 32'hbfc00124);
    do_update(1, 0, 0, 0, 1, $urandom_range(0, PHT_N - 1), 32'hbfc00110, 32'hbfc00200);
    pc_in = 32'hbfc00010;
    #1;
    checks++;
    if ({pred_taken, next_pc_out} !== {1'b0, 32'hbfc00014}) begin
      failures++;
      $display("FAIL alias_miss got %h want %h", {pred_taken, next_pc_out}, {1'b0, 32'hbfc00014});
    end
    pc_in = 32'hbfc00110;
    #1;
    exp_v = model_predict(pc_in);
    checks++;
    if ({pred_taken, pred_pht_index, next_pc_out} !== exp_v) begin
      failures++;
      $display("FAIL alias_new got %h want %h", {pred_taken, pred_pht_index, next_pc_out}, exp_v);
    end
  endtask

  task automatic test_same_cycle();
    set_update(0, 1, 0, 0, 1, 0, 32'hbfc00030, 32'hbfc00a00);
    pc_in = 32'hbfc00030;
    #1;
    checks++;
    if ({pred_taken, next_pc_out} !== {1'b0, 32'hbfc00034}) begin
      failures++;
      $display("FAIL same_cycle_old got %h want %h", {pred_taken, next_pc_out}, {1'b0, 32'hbfc00034});
    end
    step();
    pc_in = 32'hbfc00030;
    #1;
    checks++;
    if ({pred_taken, next_pc_out} !== {1'b1, 32'hbfc00a00}) begin
      failures++;
      $display("FAIL same_cycle_new got %h want %h", {pred_taken, next_pc_out}, {1'b1, 32'hbfc00a00});
    end
  endtask

`ifdef BP_RAS_EN
  task automatic test_ras();
    logic [31:0] exp_pc;
    do_update(0, 1, 1, 0, 1, 0, 32'hbfc00100, 32'hbfc00800);
    do_update(0, 1, 0, 1, 1, 0, 32'hbfc00810, 32'hbfc00108);
    do_update(0, 1, 1, 0, 1, 0, 32'hbfc00200, 32'hbfc00800);
    pc_in = 32'hbfc00810;
    #1;
    checks++;
    if ({pred_taken, next_pc_out} !== {1'b1, 32'hbfc00208}) begin
      failures++;
      $display("FAIL ras_setup got %h want %h", {pred_taken, next_pc_out}, {1'b1, 32'hbfc00208});
    end
    for (int i = 0; i < 9; i++)
      do_update(0, 1, 1, 0, 1, 0, 32'hbfc01000 + 32'(i * 'h40), 32'hbfc00800);
    // Ten pushes into eight slots: calls 1..8 survive, newest first.
    for (int k = 0; k < 8; k++) begin
      exp_pc = 32'hbfc01000 + 32'((8 - k) * 'h40) + 32'd8;
      pc_in = 32'hbfc00810;
      #1;
      checks++;
      if ({pred_taken, next_pc_out} !== {1'b1, exp_pc}) begin
        failures++;
        $display("FAIL ras_return_%0d got %h want %h", k, {pred_taken, next_pc_out}, {1'b1, exp_pc});
      end
      do_update(0, 1, 0, 1, 1, 0, 32'hbfc00810, exp_pc);
    end
    pc_in = 32'hbfc00810;
    #1;
    checks++;
    if ({pred_taken, next_pc_out} !== {1'b1, 32'hbfc01048}) begin
      failures++;
      $display("FAIL ras_empty_fallback got %h want %h", {pred_taken, next_pc_out},
               {1'b1, 32'hbfc01048});
    end
  endtask
`endif

  task automatic test_random();
    logic [G+32:0] exp_v;
    logic [31:0]   pc_a, pc_b;
    for (int n = 0; n < 400; n++) begin
      pc_a = 32'hbfc00000 | (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 8);
      pc_b = 32'hbfc00000 | (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 8);
      set_update($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, PHT_N - 1), pc_a, $urandom() & 32'hffff_fffc);
      upd_valid = ($urandom_range(0, 3) != 0);
      pc_in = pc_b;
      #1;
      exp_v = model_predict(pc_in);
      checks++;
      if ({pred_taken, pred_pht_index, next_pc_out} !== exp_v) begin
        failures++;
        $display("FAIL random_%0d pc=%h got %h want %h", n, pc_in,
                 {pred_taken, pred_pht_index, next_pc_out}, exp_v);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    logic [G+32:0] exp_v;
    do_update(1, 0, 0, 0, 1, 4, 32'hbfc00010, 32'hbfc00124);
    do_update(0, 1, 0, 0, 1, 0, 32'hbfc00020, 32'hbfc00400);
    #2;
    rst = 0;
    model_reset();
    pc_in = 32'hbfc00010;
    #1;
    checks++;
    if ({pred_taken, pred_pht_index, next_pc_out} !== {1'b0, 5'h04, 32'hbfc00014}) begin
      failures++;
      $display("FAIL async_reset got %h want %h", {pred_taken, pred_pht_index, next_pc_out},
               {1'b0, 5'h04, 32'hbfc00014});
    end
    set_update(0, 1, 0, 0, 1, 0, 32'hbfc00010, 32'hbfc00f00);
    step();
    #3;
    rst = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      pc_in = (i == 0) ? 32'hbfc00010 : 32'hbfc00020;
      #1;
      exp_v = model_predict(pc_in);
      checks++;
      if ({pred_taken, pred_pht_index, next_pc_out} !== exp_v) begin
        failures++;
        $display("FAIL post_reset_%0d got %h want %h", i, {pred_taken, pred_pht_index, next_pc_out},
                 exp_v);
      end
    end
  endtask

  initial begin
    idle_inputs();
    pc_in = '0;
    rst = 0;
    model_reset();
    #23;
    rst = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_first_branch();
    test_jump();
    test_pht_saturation();
    test_alias();
    test_same_cycle();
`ifdef BP_RAS_EN
    test_ras();
`endif
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
